elevator_call_sched: RTL

Call scheduler and door controller sitting directly upstream of the elevator floor FSM (`mef_elevator`). It latches hall/cabin call buttons for the three floors and picks the next target floor using collective up/down ordering. It times the door-open interval and drives the FSM's `P` (door closed/run enable) and target code `B0`/`B1`. It reads back the FSM's current-floor code `EA` to detect arrival and clear served calls.

---
 rtl/elevator_pkg.sv | 49 ++++
 rtl/elevator_call_sched_if.sv | 21 ++
 rtl/elevator_call_sched_call_latch.sv | 60 ++++++
 rtl/elevator_call_sched.sv | 126 ++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// +--------------------------------------------------------------------------+
// | elevator_pkg                                                             |
// | Floor/target codes, scheduler state and direction types, pick helper.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package elevator_pkg;

  localparam logic [1:0] FLOOR1     = 2'b00;
  localparam logic [1:0] FLOOR2     = 2'b01;
  localparam logic [1:0] FLOOR3     = 2'b10;
  localparam logic [1:0] EA_INVALID = 2'b11;

  localparam logic [1:0] TGT_FLOOR1 = 2'b00;
  localparam logic [1:0] TGT_FLOOR2 = 2'b01;
  localparam logic [1:0] TGT_FLOOR3 = 2'b10;
  localparam logic [1:0] HOLD       = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    DOOR_OPEN = 2'b01,
    MOVING    = 2'b10
  } sched_state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Returns {found, floor}: nearest pending floor strictly beyond cur in dir.
  function automatic logic [2:0] nearest_pending(input logic [2:0] pend,
                                                 input logic [1:0] cur,
                                                 input dir_t       dir);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (dir == DIR_UP) begin
        if (pend[i] && (i > int'(cur)) && !r[2]) r = {1'b1, 2'(i)};
      end else begin
        if (pend[i] && (i < int'(cur))) r = {1'b1, 2'(i)};
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/elevator_call_sched_if.sv
// +--------------------------------------------------------------------------+
// | elevator_call_sched_if                                                   |
// | Call buttons, floor feedback and FSM control lines of the scheduler.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface elevator_call_sched_if;
  logic [2:0] call_btn;
  logic [1:0] EA;
  logic       P;
  logic       B0;
  logic       B1;
  logic [2:0] pending;
  logic       door_open;

  modport master (output call_btn, EA, input P, B0, B1, pending, door_open);
  modport slave  (input call_btn, EA, output P, B0, B1, pending, door_open);
endinterface

`default_nettype wire

// File: rtl/elevator_call_sched_call_latch.sv
// +--------------------------------------------------------------------------+
// | call_latch                                                               |
// | Optional 2-flop button synchronizer (ELEV_CALL_SYNC_EN), rising-edge     |
// | detect and pending-call register with per-bit clear.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module call_latch #(
  parameter int WIDTH = 3
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic [WIDTH-1:0] i_btn,
  input  wire logic [WIDTH-1:0] i_clr,
  output logic      [WIDTH-1:0] o_rise,
  output logic      [WIDTH-1:0] o_pending
);

  logic [WIDTH-1:0] w_btn;
  logic [WIDTH-1:0] r_btn_d;
  logic [WIDTH-1:0] r_pending;

`ifdef ELEV_CALL_SYNC_EN
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn = r_sync2;
`else
  assign w_btn = i_btn;
`endif

  assign o_rise = w_btn & ~r_btn_d;

  // Clear is applied after set so a served floor's same-cycle press is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_d   <= '0;
      r_pending <= '0;
    end else begin
      r_btn_d   <= w_btn;
      r_pending <= (r_pending | o_rise) & ~i_clr;
    end
  end

  assign o_pending = r_pending;

endmodule

`default_nettype wire

// File: rtl/elevator_call_sched.sv
// +--------------------------------------------------------------------------+
// | elevator_call_sched                                                      |
// | Collective up/down call scheduler and door timer for mef_elevator.       |
// | Option macro: ELEV_CALL_SYNC_EN (button synchronizer in call_latch).     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module elevator_call_sched
  import elevator_pkg::*;
#(
  parameter int DOOR_CYC = 8
) (
  input wire logic            clk,
  input wire logic            reset,
  elevator_call_sched_if.slave bus
);

  localparam logic [7:0] c_door_cyc = 8'(DOOR_CYC);

  sched_state_t r_state, w_state_nxt;
  dir_t         r_dir, w_dir_nxt, w_dir_rev;
  logic [1:0]   r_target, w_target_nxt;
  logic [7:0]   r_timer, w_timer_nxt;
  logic         r_p, r_b0, r_b1, r_door_open;

  logic [2:0]   w_clr, w_rise, w_pending;
  logic [2:0]   w_cur_mask, w_tgt_mask;
  logic [2:0]   w_sel_fwd, w_sel_rev;
  logic         w_ea_valid, w_cur_pend, w_cur_rise;

  call_latch #(.WIDTH(3)) u_call_latch (
    .clk       (clk),
    .reset     (reset),
    .i_btn     (bus.call_btn),
    .i_clr     (w_clr),
    .o_rise    (w_rise),
    .o_pending (w_pending)
  );

  assign w_ea_valid = (bus.EA != EA_INVALID);
  assign w_cur_mask = w_ea_valid ? (3'b001 << bus.EA) : 3'b000;
  assign w_tgt_mask = 3'b001 << r_target;
  assign w_cur_pend = |(w_pending & w_cur_mask);
  assign w_cur_rise = |(w_rise & w_cur_mask);
  assign w_dir_rev  = (r_dir == DIR_UP) ? DIR_DOWN : DIR_UP;
  assign w_sel_fwd  = nearest_pending(w_pending, bus.EA, r_dir);
  assign w_sel_rev  = nearest_pending(w_pending, bus.EA, w_dir_rev);

  always_comb begin
    w_state_nxt  = r_state;
    w_dir_nxt    = r_dir;
    w_target_nxt = r_target;
    w_timer_nxt  = r_timer;
    w_clr        = 3'b000;
    case (r_state)
      IDLE: begin
        if (w_ea_valid) begin
          if (w_cur_pend) begin
            w_clr       = w_cur_mask;
            w_timer_nxt = c_door_cyc;
            w_state_nxt = DOOR_OPEN;
          end else if (|w_pending) begin
            if (w_sel_fwd[2]) begin
              w_target_nxt = w_sel_fwd[1:0];
            end else begin
              w_target_nxt = w_sel_rev[1:0];
              w_dir_nxt    = w_dir_rev;
            end
            w_state_nxt = MOVING;
          end
        end
      end
      DOOR_OPEN: begin
        if (w_cur_rise) begin
          w_clr       = w_cur_mask;
          w_timer_nxt = c_door_cyc;
        end else if (r_timer <= 8'd1) begin
          w_timer_nxt = 8'd0;
          w_state_nxt = IDLE;
        end else begin
          w_timer_nxt = r_timer - 8'd1;
        end
      end
      MOVING: begin
        // EA is already registered by the floor FSM, so it is compared directly.
        if (w_ea_valid && (bus.EA == r_target)) begin
          w_clr       = w_tgt_mask;
          w_timer_nxt = c_door_cyc;
          w_state_nxt = DOOR_OPEN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_dir       <= DIR_UP;
      r_target    <= FLOOR1;
      r_timer     <= 8'd0;
      r_p         <= 1'b0;
      r_b0        <= HOLD[1];
      r_b1        <= HOLD[0];
      r_door_open <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_dir       <= w_dir_nxt;
      r_target    <= w_target_nxt;
      r_timer     <= w_timer_nxt;
      r_p         <= (w_state_nxt == MOVING);
      r_door_open <= (w_state_nxt != MOVING);
      {r_b0, r_b1} <= (w_state_nxt == MOVING) ? w_target_nxt : HOLD;
    end
  end

  assign bus.P         = r_p;
  assign bus.B0        = r_b0;
  assign bus.B1        = r_b1;
  assign bus.door_open = r_door_open;
  assign bus.pending   = w_pending;

endmodule

`default_nettype wire
